// File: rtl/video_timing_sync.sv
// video_timing_sync
// LCD timing generator that drains a frame-buffer FIFO in lock with the
// camera frame. On each camera frame start, the FIFO is cleared. The block then
// waits for a minimum fill level and emits exactly one frame of hs/vs/de, with
// pixel data aligned to de. It also raises a sticky underflow flag. With
// LOCKED_MODE=0 it free-runs from reset and ignores the camera.
//
// Ports
//   video_clk     pixel clock (only clock)
//   rst           asynchronous active-high reset
//   frame_sync_in camera vsync, already in video_clk domain; rising edge = frame start
//   fifo_q        FIFO read data, valid one cycle after fifo_rd_en
//   fifo_level    FIFO read-side word count
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO read request (active pixel of a running frame)
//   fifo_clr      one-cycle FIFO clear pulse
//   hs, vs, de    LCD timing, two cycles behind the counters
//   vout_data     pixel data, forced to 0 outside de
//   locked        a locked frame is being output
//   underflow     sticky: a read was issued while the FIFO was empty
module video_timing_sync #(
  parameter int DATA_WIDTH  = 16,
  parameter int LEVEL_W     = 10,
  parameter int H_ACTIVE    = 480,
  parameter int H_FP        = 2,
  parameter int H_SYNC      = 41,
  parameter int H_BP        = 2,
  parameter int V_ACTIVE    = 272,
  parameter int V_FP        = 2,
  parameter int V_SYNC      = 10,
  parameter int V_BP        = 2,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int START_LEVEL = 480,
  parameter bit LOCKED_MODE = 1'b1
) (
  input  logic                  video_clk,
  input  logic                  rst,
  input  logic                  frame_sync_in,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic [LEVEL_W-1:0]    fifo_level,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  fifo_clr,
  output logic                  hs,
  output logic                  vs,
  output logic                  de,
  output logic [DATA_WIDTH-1:0] vout_data,
  output logic                  locked,
  output logic                  underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  localparam state_t RST_STATE = LOCKED_MODE ? IDLE : RUN;

  state_t        state;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          sync_q, pend;
  logic          rise, act, frame_end, level_ok, hs_raw, vs_raw;
  logic [2:1]    vld_pipe, hs_pipe, vs_pipe;

  assign rise      = frame_sync_in & ~sync_q;
  assign act       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign level_ok  = fifo_level >= LEVEL_W'(START_LEVEL);
  assign hs_raw    = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs_raw    = (v_cnt >= V_SS) && (v_cnt < V_SE);

  // Gated by rst so the free-running variant (reset state RUN, counters at
  // the first active pixel) does not request data while held in reset.
  assign fifo_rd_en = act && (state == RUN) && !rst;
  assign locked     = LOCKED_MODE && (state == RUN);

  always_comb begin
    h_nxt = h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
  end

  // Frame control. Counters sit at 0 outside RUN, so leaving RUN at the
  // frame's last cycle (where they wrap to 0) needs no explicit counter reset.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state     <= RST_STATE;
      h_cnt     <= '0;
      v_cnt     <= '0;
      sync_q    <= 1'b0;
      pend      <= 1'b0;
      fifo_clr  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sync_q   <= frame_sync_in;
      fifo_clr <= 1'b0;
      if (fifo_rd_en && fifo_empty) underflow <= 1'b1;
      if (!LOCKED_MODE) begin
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
      end else begin
        unique case (state)
          IDLE: if (rise) begin
            fifo_clr  <= 1'b1;
            underflow <= 1'b0;
            state     <= FILL;
          end
          FILL: begin
            // A new camera frame during fill restarts the fill from empty.
            if (rise) begin
              fifo_clr  <= 1'b1;
              underflow <= 1'b0;
            end else if (level_ok) begin
              state <= RUN;
            end
          end
          RUN: begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (rise) pend <= 1'b1;
            if (frame_end) begin
              // A rise on the very last cycle counts as pending too.
              if (pend || rise) begin
                fifo_clr  <= 1'b1;
                underflow <= 1'b0;
                pend      <= 1'b0;
                state     <= FILL;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Two-stage output pipeline. Stage 1 captures the timing of the cycle in
  // which the read is issued; stage 2 lines up with fifo_q, which arrives one
  // cycle after the read.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      hs_pipe   <= '0;
      vs_pipe   <= '0;
      vout_data <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[1], fifo_rd_en};
      hs_pipe   <= {hs_pipe[1], hs_raw};
      vs_pipe   <= {vs_pipe[1], vs_raw};
      vout_data <= vld_pipe[1] ? fifo_q : '0;
    end
  end

  assign de = vld_pipe[2];
  assign hs = hs_pipe[2] ? HS_POL : ~HS_POL;
  assign vs = vs_pipe[2] ? VS_POL : ~VS_POL;

endmodule
